// File: rtl/multi_reg_xfer_seq_pkg.sv
// Shared constants and state encoding for the SWM/LWM register-list sequencer.
package multi_reg_xfer_seq_pkg;

   localparam int MASK_W     = 21;
   localparam int ADDR_W     = 32;
   localparam int IDX_W      = 5;
   localparam int WORD_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      DONE = 2'd2
   } xfer_state_t;

endpackage : multi_reg_xfer_seq_pkg

// File: rtl/multi_reg_xfer_seq_lsb_prio_enc.sv
// Lowest-set-bit priority encoder: index of the least significant 1 plus a
// valid flag. Kept standalone so the hazard logic can reuse it.
module lsb_prio_enc #(
   parameter int W  = 21,
   parameter int IW = 5
) (
   input  logic [W-1:0]  mask_i,
   output logic [IW-1:0] idx_o,
   output logic          valid_o
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      idx_o   = {IW{1'b0}};
      valid_o = |mask_i;
      for (int i = W - 1; i >= 0; i--) begin
         idx_o = mask_i[i] ? IW'(i) : idx_o;
      end
   end

endmodule : lsb_prio_enc

// File: rtl/multi_reg_xfer_seq.sv
// Store/load-multiple sequencer: latches a register-list mask and a base
// address, then issues one word transfer per set bit, lowest register first,
// at consecutive word addresses while holding the pipeline stalled.
module multi_reg_xfer_seq
   import multi_reg_xfer_seq_pkg::*;
#(
   parameter int P_MASK_W     = MASK_W,
   parameter int P_ADDR_W     = ADDR_W,
   parameter int P_IDX_W      = IDX_W,
   parameter int P_WORD_BYTES = WORD_BYTES
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic                is_load_i,
   input  logic [P_MASK_W-1:0] addrcode_i,
   input  logic [P_ADDR_W-1:0] base_i,
   input  logic                mem_ready_i,
   output logic                stall_o,
   output logic                busy_o,
   output logic [P_IDX_W-1:0]  reg_idx_o,
   output logic [P_ADDR_W-1:0] mem_addr_o,
   output logic                memwrite_o,
   output logic                memread_o,
   output logic                regwrite_o,
   output logic                done_o
);

   xfer_state_t         state_q, state_d;
   logic [P_MASK_W-1:0] mask_q,  mask_d;
   logic [P_ADDR_W-1:0] base_q,  base_d;
   logic [P_IDX_W:0]    k_q,     k_d;
   logic                load_q,  load_d;

   logic [P_IDX_W-1:0]  enc_idx_s;
   logic                enc_valid_s;
   logic [P_MASK_W-1:0] mask_clr_s;
   logic [P_ADDR_W-1:0] beat_addr_s;

   lsb_prio_enc #(
      .W  (P_MASK_W),
      .IW (P_IDX_W)
   ) u_lsb_prio_enc (
      .mask_i  (mask_q),
      .idx_o   (enc_idx_s),
      .valid_o (enc_valid_s)
   );

   // x & (x-1) drops exactly the lowest set bit, i.e. the register just
   // transferred. Address wraps silently modulo 2^ADDR_W.
   assign mask_clr_s  = mask_q & (mask_q - P_MASK_W'(1));
   assign beat_addr_s = base_q + (P_ADDR_W'(k_q) * P_ADDR_W'(P_WORD_BYTES));

   // Next-state and output decode; every output defaults to 0 so IDLE and
   // DONE can never present a memory beat.
   always_comb begin
      state_d    = state_q;
      mask_d     = mask_q;
      base_d     = base_q;
      k_d        = k_q;
      load_d     = load_q;
      stall_o    = 1'b0;
      busy_o     = 1'b0;
      reg_idx_o  = {P_IDX_W{1'b0}};
      mem_addr_o = {P_ADDR_W{1'b0}};
      memwrite_o = 1'b0;
      memread_o  = 1'b0;
      regwrite_o = 1'b0;
      done_o     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               mask_d  = addrcode_i;
               base_d  = base_i;
               load_d  = is_load_i;
               k_d     = {(P_IDX_W + 1){1'b0}};
               stall_o = 1'b1;
               state_d = (addrcode_i != {P_MASK_W{1'b0}}) ? XFER : DONE;
            end else begin
               state_d = IDLE;
            end
         end
         XFER: begin
            stall_o    = 1'b1;
            busy_o     = 1'b1;
            reg_idx_o  = enc_idx_s;
            mem_addr_o = beat_addr_s;
            memwrite_o = enc_valid_s & ~load_q;
            memread_o  = enc_valid_s & load_q;
            regwrite_o = enc_valid_s & load_q & mem_ready_i;
            if (mem_ready_i) begin
               mask_d  = mask_clr_s;
               k_d     = k_q + {{P_IDX_W{1'b0}}, 1'b1};
               state_d = (mask_clr_s == {P_MASK_W{1'b0}}) ? DONE : XFER;
            end else begin
               state_d = XFER;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and latched-operand registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         mask_q  <= {P_MASK_W{1'b0}};
         base_q  <= {P_ADDR_W{1'b0}};
         k_q     <= {(P_IDX_W + 1){1'b0}};
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         base_q  <= base_d;
         k_q     <= k_d;
         load_q  <= load_d;
      end
   end

endmodule : multi_reg_xfer_seq

// File: tb/tb_multi_reg_xfer_seq.sv
// Directed bench for multi_reg_xfer_seq with a beat scoreboard.
module tb_multi_reg_xfer_seq;
   import multi_reg_xfer_seq_pkg::*;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] addr;
      logic        load;
   } beat_t;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        start_i;
   logic        is_load_i;
   logic [20:0] addrcode_i;
   logic [31:0] base_i;
   logic        mem_ready_i;
   logic        stall_o, busy_o, memwrite_o, memread_o, regwrite_o, done_o;
   logic [4:0]  reg_idx_o;
   logic [31:0] mem_addr_o;

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;
   int    ready_gap = 0;
   int    gap_cnt = 0;
   bit    saw_done;

   multi_reg_xfer_seq dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .is_load_i(is_load_i),
      .addrcode_i(addrcode_i), .base_i(base_i), .mem_ready_i(mem_ready_i),
      .stall_o(stall_o), .busy_o(busy_o), .reg_idx_o(reg_idx_o),
      .mem_addr_o(mem_addr_o), .memwrite_o(memwrite_o), .memread_o(memread_o),
      .regwrite_o(regwrite_o), .done_o(done_o)
   );

   initial begin
      forever #5 clk_i = ~clk_i;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check(tag, {stall_o, busy_o, reg_idx_o, mem_addr_o, memwrite_o, memread_o,
                  regwrite_o, done_o}, 64'd0);
   endtask

   // Sample the current cycle (inputs already driven), score beats, advance.
   task automatic cyc();
      beat_t b;
      mem_ready_i = (gap_cnt == ready_gap);
      #1;
      saw_done = done_o;
      if (done_o) begin
         check("done_stall", {63'd0, stall_o}, 64'd0);
         check("done_busy", {63'd0, busy_o}, 64'd0);
      end
      if (memwrite_o || memread_o) begin
         check("rw_exclusive", {63'd0, memwrite_o & memread_o}, 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_beat", {59'd0, reg_idx_o}, 64'hFFFF);
         end else if (mem_ready_i) begin
            b = sb.pop_front();
            check("beat_idx", {59'd0, reg_idx_o}, {59'd0, b.idx});
            check("beat_addr", {32'd0, mem_addr_o}, {32'd0, b.addr});
            check("beat_dir", {62'd0, memread_o, memwrite_o}, {62'd0, b.load, ~b.load});
            check("beat_regwrite", {63'd0, regwrite_o}, {63'd0, b.load});
            gap_cnt = 0;
         end else begin
            b = sb[0];
            check("hold_idx", {59'd0, reg_idx_o}, {59'd0, b.idx});
            check("hold_addr", {32'd0, mem_addr_o}, {32'd0, b.addr});
            check("hold_regwrite", {63'd0, regwrite_o}, 64'd0);
            gap_cnt++;
         end
      end
      @(negedge clk_i);
   endtask

   // Drive a one-cycle start and push the reference beat list.
   task automatic do_start(input logic ld, input logic [20:0] mask, input logic [31:0] base);
      beat_t b;
      logic [31:0] addr;
      addr = base;
      for (int i = 0; i < 21; i++) begin
         if (mask[i]) begin
            b.idx  = 5'(i);
            b.addr = addr;
            b.load = ld;
            sb.push_back(b);
            addr = addr + 32'd4;
         end
      end
      start_i = 1'b1; is_load_i = ld; addrcode_i = mask; base_i = base;
      #1;
      check("start_stall", {63'd0, stall_o}, 64'd1);
      cyc();
      start_i = 1'b0; addrcode_i = 21'h0; base_i = 32'h0; is_load_i = 1'b0;
   endtask

   // Run until done_o; lat is the cycle index of the next sample relative to T.
   task automatic wait_done(input string tag, input int lat0, input int exp_lat);
      int lat;
      lat = lat0;
      saw_done = 1'b0;
      while (!saw_done && lat < 200) begin
         cyc();
         if (!saw_done) lat++;
      end
      check(tag, 64'(lat), 64'(exp_lat));
      check("sb_empty", 64'(sb.size()), 64'd0);
      #1;
      check_idle("idle_after_done");
   endtask

   initial begin
      rst_i = 1'b1; start_i = 1'b0; is_load_i = 1'b0;
      addrcode_i = 21'h0; base_i = 32'h0; mem_ready_i = 1'b1;
      @(negedge clk_i);
      @(negedge clk_i);
      #1;
      check_idle("reset_state");
      rst_i = 1'b0;
      cyc();
      check_idle("idle_no_start");

      // SWM two registers, ready high
      do_start(1'b0, 21'h000005, 32'h100);
      wait_done("lat_swm5", 1, 3);

      // Empty list: done next cycle, no beat
      do_start(1'b0, 21'h0, 32'h100);
      wait_done("lat_empty", 1, 1);

      // LWM with two wait cycles per beat
      ready_gap = 2; gap_cnt = 0;
      do_start(1'b1, 21'h100010, 32'h2000);
      wait_done("lat_lwm_wait", 1, 7);
      ready_gap = 0; gap_cnt = 0;

      // Full list with address wrap
      do_start(1'b0, 21'h1FFFFF, 32'hFFFFFFF0);
      wait_done("lat_full", 1, 22);

      // Reset during second beat aborts the sequence
      do_start(1'b0, 21'h0000FF, 32'h300);
      cyc();
      rst_i = 1'b1;
      cyc();
      rst_i = 1'b0;
      sb.delete();
      #1;
      check_idle("abort_idle");
      cyc();
      cyc();
      check("abort_no_beats", 64'(sb.size()), 64'd0);
      do_start(1'b0, 21'h000003, 32'h500);
      wait_done("lat_after_abort", 1, 3);

      // Start during XFER is ignored
      do_start(1'b1, 21'h00000A, 32'h400);
      start_i = 1'b1; addrcode_i = 21'h000001; base_i = 32'h999; is_load_i = 1'b0;
      cyc();
      start_i = 1'b0; addrcode_i = 21'h0; base_i = 32'h0;
      wait_done("lat_ignore_start", 2, 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_multi_reg_xfer_seq
